// File: rtl/sl2apb_master.sv
// Command-to-APB bridge: one outstanding transfer, bounded wait states with
// timeout abort, and a one-cycle response pulse.
module sl2apb_master #(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  input  logic [3:0]            cmd_strb,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [31:0]           pwdata,
  output logic [3:0]            pstrb,
  input  logic                  pready,
  input  logic [31:0]           prdata,
  input  logic                  pslverr,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  busy
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             accept;
  logic             timeout_hit;

  assign accept      = cmd_valid && cmd_ready;
  // Abort on the last allowed ACCESS cycle only when the completer is still stalling
  assign timeout_hit = (state == ACCESS) && !pready && (wait_cnt == TIMEOUT_LAST);

  // State register
  always_ff @(posedge pclk) begin
    if (preset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (pready || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    cmd_ready = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:    cmd_ready = !preset;
      SETUP:   begin psel = 1'b1; busy = 1'b1; end
      ACCESS:  begin psel = 1'b1; penable = 1'b1; busy = 1'b1; end
      RESP:    begin rsp_valid = 1'b1; busy = 1'b1; end
      default: ;
    endcase
  end

  // Command capture, wait counter and response capture
  always_ff @(posedge pclk) begin
    if (preset) begin
      paddr       <= '0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      pstrb       <= '0;
      wait_cnt    <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      if (accept) begin
        paddr    <= cmd_addr;
        pwrite   <= cmd_write;
        pwdata   <= cmd_write ? cmd_wdata : 32'd0;
        pstrb    <= cmd_write ? cmd_strb : 4'd0;
        wait_cnt <= '0;
      end else if ((state == ACCESS) && !pready) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end

      if (state == ACCESS) begin
        if (pready) begin
          rsp_rdata   <= pwrite ? 32'd0 : prdata;
          rsp_err     <= pslverr;
          rsp_timeout <= 1'b0;
        end else if (timeout_hit) begin
          rsp_rdata   <= 32'd0;
          rsp_err     <= 1'b1;
          rsp_timeout <= 1'b1;
        end
      end
    end
  end

endmodule
